dot_product_acc: RTL

DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

---
 rtl/dot_product_pkg.sv | 19 +
 rtl/dp_adder_tree.sv | 55 +++++
 rtl/dot_product_acc.sv | 110 +++++++++++
 3 files changed

// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - FSM state type and width helpers for the dot-product accumulator
package dot_product_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Accumulator width: one full product, plus growth across lanes and beats.
    function automatic int calc_aw(input int n, input int dw, input int max_beats);
        return 2 * dw + $clog2(n) + $clog2(max_beats);
    endfunction

    function automatic int calc_bw(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// rtl/dp_adder_tree.sv - combinational lane multiply and reduction to one beat sum
module dp_adder_tree #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    parameter int OW     = 2 * DW + $clog2(N)
) (
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    output logic [OW-1:0]   sum
);

    localparam int PW = 2 * DW;

    logic [OW-1:0] term [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] la;
        logic [DW-1:0] lb;
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        logic [PW-1:0] prod;

        assign la = a[i*DW +: DW];
        assign lb = b[i*DW +: DW];

        if (SIGNED != 0) begin : g_signed
            logic signed [DW-1:0] sa;
            logic signed [DW-1:0] sb;
            logic signed [PW-1:0] sp;

            assign sa   = la;
            assign sb   = lb;
            assign ea   = PW'(sa);
            assign eb   = PW'(sb);
            assign sp   = prod;
            assign term[i] = OW'(sp);
        end else begin : g_unsigned
            assign ea   = PW'(la);
            assign eb   = PW'(lb);
            assign term[i] = OW'(prod);
        end

        // Operands are pre-extended, so the low PW bits are exact for either signedness.
        assign prod = ea * eb;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + term[i];
        end
    end

endmodule

// File: rtl/dot_product_acc.sv
// rtl/dot_product_acc.sv - streaming dot-product accumulator with result hold until handshake
module dot_product_acc
    import dot_product_pkg::*;
#(
    parameter int  N         = 4,
    parameter int  DW        = 8,
    parameter int  MAX_BEATS = 16,
    parameter int  SIGNED    = 0,
    localparam int AW        = calc_aw(N, DW, MAX_BEATS),
    localparam int BW        = calc_bw(MAX_BEATS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_sum,
    output logic [BW-1:0]   out_beats,
    output logic            out_ovf
);

    state_t        state;
    logic [AW-1:0] tree_sum;
    logic [AW-1:0] beat_sum;
    logic          beat_pend;
    logic [AW-1:0] acc;
    logic [BW-1:0] beats;
    logic          ovf;
    logic          valid_q;
    logic          accept;
    logic          handshake;

    dp_adder_tree #(
        .N      (N),
        .DW     (DW),
        .SIGNED (SIGNED),
        .OW     (AW)
    ) u_tree (
        .a   (in_a),
        .b   (in_b),
        .sum (tree_sum)
    );

    assign in_ready  = (state == ACC);
    assign accept    = in_valid && in_ready;
    assign handshake = valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            beat_sum  <= '0;
            beat_pend <= 1'b0;
            acc       <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            beat_pend <= accept;
            if (accept) begin
                beat_sum <= tree_sum;
                if (beats == BW'(MAX_BEATS)) begin
                    ovf <= 1'b1;
                end else begin
                    beats <= beats + BW'(1);
                end
            end

            // Wraps modulo 2^AW when more than MAX_BEATS beats arrive.
            if (beat_pend) begin
                acc <= acc + beat_sum;
            end

            case (state)
                ACC: begin
                    if (accept && in_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state   <= HOLD;
                    valid_q <= 1'b1;
                end
                HOLD: begin
                    // beat_pend is already low here, so clearing acc cannot lose a beat.
                    if (handshake) begin
                        state   <= ACC;
                        valid_q <= 1'b0;
                        acc     <= '0;
                        beats   <= '0;
                        ovf     <= 1'b0;
                    end
                end
                default: begin
                    state   <= ACC;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = acc;
    assign out_beats = beats;
    assign out_ovf   = ovf;

endmodule
